// File: rtl/fdtd_step_seq_if.sv
// rtl/fdtd_step_seq_if.sv - control/status bundle between fdtd_step_seq and its neighbours
// perf_cyc_o exists only when FDTD_STEP_PERF_EN is defined.
interface fdtd_step_seq_if #(
  parameter int STEP_WIDTH = 16
);
  logic                  start_i;
  logic                  abort_i;
  logic [STEP_WIDTH-1:0] step_num_i;
  logic                  Hy_done_i;
  logic                  Ez_done_i;
  logic                  src_done_i;
  logic                  calc_Hy_flg_o;
  logic                  calc_Ez_flg_o;
  logic                  calc_src_flg_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  timeout_o;
  logic [STEP_WIDTH-1:0] step_cnt_o;
`ifdef FDTD_STEP_PERF_EN
  logic [31:0]           perf_cyc_o;
`endif

  modport master (
`ifdef FDTD_STEP_PERF_EN
    input  perf_cyc_o,
`endif
    output start_i, abort_i, step_num_i, Hy_done_i, Ez_done_i, src_done_i,
    input  calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o, busy_o, done_o,
    input  timeout_o, step_cnt_o
  );

  modport slave (
`ifdef FDTD_STEP_PERF_EN
    output perf_cyc_o,
`endif
    input  start_i, abort_i, step_num_i, Hy_done_i, Ez_done_i, src_done_i,
    output calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o, busy_o, done_o,
    output timeout_o, step_cnt_o
  );
endinterface

// File: rtl/fdtd_step_seq.sv
// rtl/fdtd_step_seq.sv - FDTD time-step sequencer issuing Hy/Ez/src phases per step
// Optional busy-cycle counter perf_cyc_o under FDTD_STEP_PERF_EN.
module fdtd_step_seq #(
  parameter int STEP_WIDTH = 16,
  parameter int WDOG_WIDTH = 12,
  parameter int WDOG_LIMIT = 4000
) (
  input  logic           CLK,
  input  logic           RST_N,
  fdtd_step_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    ISSUE_HY,
    WAIT_HY,
    ISSUE_EZ,
    WAIT_EZ,
    ISSUE_SRC,
    WAIT_SRC,
    STEP_CHK,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_num_q;
  logic [STEP_WIDTH-1:0] step_cnt_q;
  logic                  timeout_q;
  logic [WDOG_WIDTH-1:0] wdog_q;

  logic accept_start;
  logic cnt_inc;
  logic set_timeout;
  logic in_wait;
  logic wdog_hit;

  assign accept_start = (state_q == IDLE) && bus.start_i;
  assign in_wait      = (state_q == WAIT_HY) || (state_q == WAIT_EZ) || (state_q == WAIT_SRC);
  assign wdog_hit     = (wdog_q == WDOG_WIDTH'(WDOG_LIMIT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_inc     = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = (bus.step_num_i != '0) ? ISSUE_HY : FINISH;
        end
      end
      ISSUE_HY:  state_d = WAIT_HY;
      ISSUE_EZ:  state_d = WAIT_EZ;
      ISSUE_SRC: state_d = WAIT_SRC;
      WAIT_HY: begin
        if (bus.Hy_done_i) begin
          state_d = ISSUE_EZ;
        end else if (wdog_hit) begin
          state_d     = FINISH;
          set_timeout = 1'b1;
        end
      end
      WAIT_EZ: begin
        if (bus.Ez_done_i) begin
          state_d = ISSUE_SRC;
        end else if (wdog_hit) begin
          state_d     = FINISH;
          set_timeout = 1'b1;
        end
      end
      WAIT_SRC: begin
        if (bus.src_done_i) begin
          state_d = STEP_CHK;
        end else if (wdog_hit) begin
          state_d     = FINISH;
          set_timeout = 1'b1;
        end
      end
      STEP_CHK: begin
        cnt_inc = 1'b1;
        state_d = ((step_cnt_q + STEP_WIDTH'(1)) == step_num_q) ? FINISH : ISSUE_HY;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything decided above, including the step increment.
    if ((state_q != IDLE) && (state_q != FINISH) && bus.abort_i) begin
      state_d     = FINISH;
      cnt_inc     = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_num_q <= '0;
      step_cnt_q <= '0;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      if (accept_start) begin
        step_num_q <= bus.step_num_i;
        step_cnt_q <= '0;
        timeout_q  <= 1'b0;
      end else begin
        if (cnt_inc) begin
          step_cnt_q <= step_cnt_q + STEP_WIDTH'(1);
        end
        if (set_timeout) begin
          timeout_q <= 1'b1;
        end
      end
      // Outside WAIT states the counter sits at zero, so every WAIT entry starts fresh.
      wdog_q <= in_wait ? (wdog_q + WDOG_WIDTH'(1)) : '0;
    end
  end

`ifdef FDTD_STEP_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_q <= '0;
    end else if (accept_start) begin
      perf_q <= '0;
    end else if ((state_q != IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cyc_o = perf_q;
`endif

  assign bus.calc_Hy_flg_o  = (state_q == ISSUE_HY);
  assign bus.calc_Ez_flg_o  = (state_q == ISSUE_EZ);
  assign bus.calc_src_flg_o = (state_q == ISSUE_SRC);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.done_o         = (state_q == FINISH);
  assign bus.timeout_o      = timeout_q;
  assign bus.step_cnt_o     = step_cnt_q;

endmodule

// File: tb/tb_fdtd_step_seq.sv
// tb/tb_fdtd_step_seq.sv - randomized self-checking bench for fdtd_step_seq
// Responder answers each phase flag after a chosen delay; expectations come from a per-run phase model.
module tb_fdtd_step_seq;
  localparam int LIMIT = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  fdtd_step_seq_if #(.STEP_WIDTH(16)) bus ();

  fdtd_step_seq #(
    .STEP_WIDTH(16),
    .WDOG_WIDTH(12),
    .WDOG_LIMIT(LIMIT)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
    bus.Hy_done_i  = 1'b0;
    bus.Ez_done_i  = 1'b0;
    bus.src_done_i = 1'b0;
  endtask

  function automatic logic [2:0] flags();
    return {bus.calc_src_flg_o, bus.calc_Ez_flg_o, bus.calc_Hy_flg_o};
  endfunction

  task automatic drive_done(input int phase);
    case (phase)
      0: bus.Hy_done_i  = 1'b1;
      1: bus.Ez_done_i  = 1'b1;
      default: bus.src_done_i = 1'b1;
    endcase
  endtask

  // kill < 0: normal run. Otherwise flag index kill is either aborted on the
  // cycle its done arrives (kill_abort) or never answered (watchdog).
  task automatic run_seq(input int n, input int dly, input int kill, input bit kill_abort,
                         input bit noise);
    int d[$];
    int m, chk, exp_busy, busy_cnt, fidx, pending, cur;
    bit got_done;
    logic [2:0] f;
    for (int i = 0; i < 3 * n; i++) d.push_back((dly != 0) ? dly : int'($urandom_range(1, 5)));
    m   = (kill < 0) ? 3 * n : kill + 1;
    chk = (kill < 0) ? n : kill / 3;
    if (kill >= 0 && !kill_abort) d[kill] = LIMIT;
    exp_busy = chk + 1;
    for (int i = 0; i < m; i++) exp_busy += 1 + d[i];

    busy_cnt = 0; fidx = 0; pending = 0; cur = 2; got_done = 0;
    bus.start_i    = 1'b1;
    bus.step_num_i = 16'(n);
    for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
      tick();
      clear_inputs();
      bus.step_num_i = 16'($urandom);
      if (cyc == 0) check("timeout_clr", {31'd0, bus.timeout_o}, 0);
      if (bus.busy_o) busy_cnt++;
      f = flags();
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          drive_done(cur % 3);
          if (cur == kill && kill_abort) bus.abort_i = 1'b1;
        end
      end
      if (f != 3'b000) begin
        check("flag_onehot", $countones(f), 1);
        check("flag_order", {29'd0, f}, 32'd1 << (fidx % 3));
        check("cnt_at_flag", {16'd0, bus.step_cnt_o}, fidx / 3);
        if (fidx < m) begin
          cur     = fidx;
          pending = (fidx == kill && !kill_abort) ? 0 : d[fidx];
        end else begin
          check("flag_extra", fidx, m);
        end
        fidx++;
      end
      if (bus.done_o) begin
        got_done = 1;
        clear_inputs();
      end else if (noise) begin
        if ($urandom_range(0, 3) == 0) drive_done((cur + 1 + int'($urandom_range(0, 1))) % 3);
        bus.start_i = 1'($urandom);
      end
    end
    check("done_seen", {31'd0, got_done}, 1);
    check("flag_count", fidx, m);
    check("step_cnt", {16'd0, bus.step_cnt_o}, chk);
    check("timeout", {31'd0, bus.timeout_o}, (kill >= 0 && !kill_abort) ? 1 : 0);
    check("busy_cycles", busy_cnt, exp_busy);
`ifdef FDTD_STEP_PERF_EN
    check("perf_cyc", bus.perf_cyc_o, exp_busy);
`endif
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_quiet", {27'd0, flags(), bus.busy_o, bus.done_o}, 0);
    end
  endtask

  initial begin
    clear_inputs();
    bus.step_num_i = '0;
    RST_N = 1'b0;
    repeat (3) tick();
    check("rst_outs", {28'd0, flags(), bus.busy_o | bus.done_o | bus.timeout_o}, 0);
    check("rst_cnt", {16'd0, bus.step_cnt_o}, 0);
    RST_N = 1'b1;
    tick();

    run_seq(0, 0, -1, 0, 0);
    run_seq(3, 5, -1, 0, 0);
    run_seq(2, 0, 1, 0, 0);
    run_seq(1, 0, -1, 0, 0);
    run_seq(4, 0, 5, 1, 0);
    for (int r = 0; r < 6; r++) run_seq(int'($urandom_range(1, 4)), 0, -1, 0, 1);
    run_seq(3, 0, 4, 1, 1);

    // Asynchronous reset while parked in WAIT_EZ.
    bus.start_i    = 1'b1;
    bus.step_num_i = 16'd2;
    tick();
    bus.start_i = 1'b0;
    check("mr_hy_flag", {29'd0, flags()}, 3'b001);
    tick();
    bus.Hy_done_i = 1'b1;
    tick();
    bus.Hy_done_i = 1'b0;
    check("mr_ez_flag", {29'd0, flags()}, 3'b010);
    tick();
    tick();
    check("mr_busy", {31'd0, bus.busy_o}, 1);
    #3 RST_N = 1'b0;
    #1;
    check("mr_rst_async", {11'd0, flags(), bus.busy_o, bus.done_o, bus.timeout_o, bus.step_cnt_o}, 0);
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_quiet", {11'd0, flags(), bus.busy_o, bus.done_o, bus.timeout_o, bus.step_cnt_o}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
